// File: rtl/edge_pkg.sv
// Shared encodings for the multi-channel debounced edge detector:
// per-channel edge-select modes and the auto-repeat state machine.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    REPEAT = 2'b10
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Channel bundle between the edge detector and its user: raw inputs,
// per-channel configuration, and the debounced level / event outputs.
interface multi_edge_detector_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0]   w;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   rep_en;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   z;
  logic [N_CH-1:0]   rep;

  modport master (output w, mode, rep_en, input  level, z, rep);
  modport slave  (input  w, mode, rep_en, output level, z, rep);
endinterface

// File: rtl/edge_channel.sv
// One channel: 2-flop synchroniser, debounce counter, edge pulse generation
// and the press-and-hold auto-repeat state machine.
module edge_channel
  import edge_pkg::*;
#(
  parameter int DEB_CNT    = 500000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_w,
  input  logic [1:0] i_mode,
  input  logic       i_rep_en,
  output logic       o_level,
  output logic       o_z,
  output logic       o_rep
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int RW = $clog2(max_int(REP_DELAY, REP_PERIOD) + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

  logic          r_s1, r_s2;
  logic [DW-1:0] r_deb;
  logic          r_level, r_z, r_rep;
  rep_state_e    r_state, w_state_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;

  mode_e w_mode;
  logic  w_rise_en, w_fall_en;
  logic  w_diff, w_toggle, w_rise, w_fall;
  logic  w_edge_pulse, w_rep_pulse, w_hold;

  assign w_mode    = mode_e'(i_mode);
  assign w_rise_en = (w_mode == MODE_RISE) || (w_mode == MODE_BOTH);
  assign w_fall_en = (w_mode == MODE_FALL) || (w_mode == MODE_BOTH);

  // Toggle on the edge where the counter would reach DEB_CNT.
  assign w_diff   = r_s2 ^ r_level;
  assign w_toggle = w_diff && (r_deb == DEB_LAST);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle && r_level;

  assign w_edge_pulse = (w_rise && w_rise_en) || (w_fall && w_fall_en);

  // A falling edge leaves the repeat states with no repeat pulse on that edge.
  assign w_hold = r_level && !w_fall && i_rep_en && w_rise_en;

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rep_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && i_rep_en && w_rise_en) begin
          w_state_nxt = WAIT;
          w_rcnt_nxt  = '0;
        end
      end
      WAIT: begin
        if (!w_hold) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == DLY_LAST) begin
          w_state_nxt = REPEAT;
          w_rcnt_nxt  = '0;
          w_rep_pulse = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!w_hold) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == PER_LAST) begin
          w_rcnt_nxt  = '0;
          w_rep_pulse = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= '0;
      r_level <= 1'b0;
      r_z     <= 1'b0;
      r_rep   <= 1'b0;
      r_state <= IDLE;
      r_rcnt  <= '0;
    end else begin
      r_s1 <= i_w;
      r_s2 <= r_s1;
      if (w_toggle) begin
        r_level <= ~r_level;
        r_deb   <= '0;
      end else if (w_diff) begin
        r_deb <= r_deb + 1'b1;
      end else begin
        r_deb <= '0;
      end
      r_z     <= w_edge_pulse || w_rep_pulse;
      r_rep   <= w_rep_pulse;
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  assign o_level = r_level;
  assign o_z     = r_z;
  assign o_rep   = r_rep;

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent debounced edge detectors with optional auto-repeat,
// one edge_channel instance per input.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int DEB_CNT    = 500000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_edge_detector_if.slave  bus
);
  logic [N_CH-1:0] w_level, w_z, w_rep;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      edge_channel #(
        .DEB_CNT   (DEB_CNT),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .i_w     (bus.w[gi]),
        .i_mode  (bus.mode[2*gi+1 -: 2]),
        .i_rep_en(bus.rep_en[gi]),
        .o_level (w_level[gi]),
        .o_z     (w_z[gi]),
        .o_rep   (w_rep[gi])
      );
    end
  endgenerate

  assign bus.level = w_level;
  assign bus.z     = w_z;
  assign bus.rep   = w_rep;

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have parameter N_CH, default 5: number of independent input channels (1..16).
REQ-002 The block SHALL have parameter DEB_CNT, default 500000: consecutive clock cycles a changed input must hold before it is accepted (minimum 1).
REQ-003 The block SHALL have parameter REP_DELAY, default 50000000: cycles from an accepted rising edge to the first auto-repeat pulse (minimum 2).
REQ-004 The block SHALL have parameter REP_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses (minimum 1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port w, input, N_CH bits: raw asynchronous inputs, such as buttons or switches.
REQ-008 The block SHALL have port mode, input, 2*N_CH bits: per-channel edge select in bits [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
REQ-009 The block SHALL have port rep_en, input, N_CH bits: per-channel auto-repeat enable.
REQ-010 The block SHALL have port level, output, N_CH bits: debounced, registered input level.
REQ-011 The block SHALL have port z, output, N_CH bits: one-cycle event pulse per channel.
REQ-012 The block SHALL have port rep, output, N_CH bits: high together with z[i] only when that pulse is an auto-repeat pulse.

Function
REQ-013 Each w[i] SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Each channel SHALL keep a debounce counter, width $clog2(DEB_CNT+1). The counter increments while the synchronised input differs from level[i] and clears whenever they are equal.
REQ-015 When the counter reaches DEB_CNT, level[i] SHALL toggle on that same edge and the counter SHALL clear.
REQ-016 Latency: a clean input change first sampled at edge 1 SHALL update level[i] at edge DEB_CNT+2.
REQ-017 Glitch rejection: a change lasting fewer than DEB_CNT synchronised cycles SHALL leave level[i], z[i] and rep[i] unchanged.
REQ-018 z[i] SHALL assert for exactly one cycle, in the same cycle level[i] changes, when the change direction is enabled by mode[i]. Mode 00 SHALL produce no pulses.
REQ-019 Each channel SHALL run a repeat FSM with states IDLE, WAIT and REPEAT, and a repeat counter of width $clog2(max(REP_DELAY,REP_PERIOD)+1).
REQ-020 IDLE -> WAIT SHALL occur on an accepted rising edge when rep_en[i]=1 and mode[i] bit 0 = 1; the repeat counter clears.
REQ-021 In WAIT, when the counter reaches REP_DELAY-1, the FSM SHALL move to REPEAT, pulse z[i] and rep[i] for one cycle, and clear the counter.
REQ-022 In REPEAT, z[i] and rep[i] SHALL pulse every REP_PERIOD cycles while level[i]=1.
REQ-023 In WAIT or REPEAT, the FSM SHALL return to IDLE on the next edge if level[i] falls, rep_en[i] falls, or mode[i] bit 0 clears; no further repeat pulses follow.
REQ-024 If a falling-edge pulse and an exit condition occur together, the falling pulse SHALL still be emitted as a normal pulse with rep[i]=0.
REQ-025 Changes to mode and rep_en SHALL take effect on the next clock edge; mode and rep_en are not synchronised and are assumed to be synchronous to clk.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL clear the synchronisers, debounce counters, repeat counters and level, z and rep to 0, and force all FSMs to IDLE.
REQ-028 After reset release with w[i] held high, the block SHALL accept a rising edge after DEB_CNT+2 cycles and report it per mode[i].
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no residual pulse.

Structure
REQ-030 A shared package edge_pkg SHALL hold the mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the repeat-state enum (IDLE, WAIT, REPEAT).
REQ-031 One sub-module, edge_channel, SHALL implement a single channel (synchroniser, debounce, edge detect, repeat FSM). The top SHALL instantiate it N_CH times using a generate loop.

Verification (N_CH=2, DEB_CNT=4, REP_DELAY=10, REP_PERIOD=3)
REQ-032 Clean press, w[0] 0->1 held, mode 01 -> level[0] rises at edge 6 with a single z[0] pulse and rep[0]=0; z[1] stays 0.
REQ-033 A 3-cycle high glitch on w[0] -> level[0], z[0] and rep[0] remain 0.
REQ-034 Mode 11 with a press held 8 cycles then released -> exactly two z[0] pulses, on the rise and on the fall.
REQ-035 rep_en[0]=1 with the button held 20 cycles after the accepted rise -> z[0]+rep[0] pulses at +10, +13, +16 and +19; none after release is accepted.
REQ-036 reset=0 asserted mid-WAIT, w held high, released -> all outputs 0, then one z[0] pulse 6 cycles after release and none before.
REQ-037 Both channels pressed in the same cycle, mode 01 -> z[0] and z[1] pulse in the same cycle.
